// File: rtl/csr_if.sv
// CSR access bus between the execute-stage CSR datapath (master) and the CSR file (slave).
interface csr_if #(
  parameter int XLEN = 32
);
  logic            csr_valid;
  logic            csr_stall;
  logic            csr_kill;
  logic [11:0]     csr_addr;
  logic [1:0]      csr_op;
  logic            csr_src_zero;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_illegal;

  modport master (
    output csr_valid, csr_stall, csr_kill, csr_addr, csr_op, csr_src_zero, csr_wdata,
    input  csr_rdata, csr_illegal
  );

  modport slave (
    input  csr_valid, csr_stall, csr_kill, csr_addr, csr_op, csr_src_zero, csr_wdata,
    output csr_rdata, csr_illegal
  );
endinterface

// File: rtl/csr_file.sv
// CSR file: tohost plus 64-bit cycle/instret counters with read-only user aliases.
// Reads are combinational and return the pre-edge value; writes commit on the clock edge.
module csr_file #(
  parameter int              XLEN         = 32,
  parameter logic [11:0]     TOHOST_ADDR  = 12'h51E,
  parameter logic [XLEN-1:0] TOHOST_RESET = '0
) (
  input  logic            clk,
  input  logic            rst,
  csr_if.slave            bus,
  input  logic            instret_inc,
  output logic [XLEN-1:0] tohost
);

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  logic [2*XLEN-1:0] mcycle, mcycle_nxt;
  logic [2*XLEN-1:0] minstret, minstret_nxt;

  logic            mapped;
  logic            read_only;
  logic [XLEN-1:0] old_val;
  logic [XLEN-1:0] new_val;
  logic            wr_intent;
  logic            illegal;
  logic            commit;

  always_comb begin
    mapped    = 1'b1;
    read_only = 1'b0;
    old_val   = '0;
    case (bus.csr_addr)
      TOHOST_ADDR: old_val = tohost;
      12'hB00:     old_val = mcycle[XLEN-1:0];
      12'hB80:     old_val = mcycle[2*XLEN-1:XLEN];
      12'hB02:     old_val = minstret[XLEN-1:0];
      12'hB82:     old_val = minstret[2*XLEN-1:XLEN];
      12'hC00, 12'hC01: begin
        old_val   = mcycle[XLEN-1:0];
        read_only = 1'b1;
      end
      12'hC80, 12'hC81: begin
        old_val   = mcycle[2*XLEN-1:XLEN];
        read_only = 1'b1;
      end
      12'hC02: begin
        old_val   = minstret[XLEN-1:0];
        read_only = 1'b1;
      end
      12'hC82: begin
        old_val   = minstret[2*XLEN-1:XLEN];
        read_only = 1'b1;
      end
      default: mapped = 1'b0;
    endcase
  end

  // csrrs/csrrc with a zero source are pure reads, which keeps them legal on RO aliases.
  assign wr_intent = (bus.csr_op == OP_RW) ||
                     ((bus.csr_op != OP_NONE) && !bus.csr_src_zero);

  assign illegal = bus.csr_valid && (bus.csr_op != OP_NONE) &&
                   (!mapped || (read_only && wr_intent));

  assign commit = bus.csr_valid && !bus.csr_stall && !bus.csr_kill && !illegal && wr_intent;

  always_comb begin
    case (bus.csr_op)
      OP_RW:   new_val = bus.csr_wdata;
      OP_RS:   new_val = old_val | bus.csr_wdata;
      OP_RC:   new_val = old_val & ~bus.csr_wdata;
      default: new_val = old_val;
    endcase
  end

  assign bus.csr_rdata   = bus.csr_valid ? old_val : '0;
  assign bus.csr_illegal = illegal;

  // A software write overrides only the half it targets; the other half keeps the increment.
  always_comb begin
    mcycle_nxt   = mcycle + 1'b1;
    minstret_nxt = minstret + (2*XLEN)'(instret_inc);
    if (commit) begin
      case (bus.csr_addr)
        12'hB00: mcycle_nxt[XLEN-1:0]        = new_val;
        12'hB80: mcycle_nxt[2*XLEN-1:XLEN]   = new_val;
        12'hB02: minstret_nxt[XLEN-1:0]      = new_val;
        12'hB82: minstret_nxt[2*XLEN-1:XLEN] = new_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tohost   <= TOHOST_RESET;
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      mcycle   <= mcycle_nxt;
      minstret <= minstret_nxt;
      if (commit && (bus.csr_addr == TOHOST_ADDR))
        tohost <= new_val;
    end
  end

endmodule
